// File: rtl/depthwise_mram_writer_pkg.sv
// Shared types, widths and helpers for the depthwise feature-map MRAM writer.
package depthwise_mram_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_W     = LANES * LANE_W;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned FILL_CNT_W = 3;
  localparam int unsigned PIX_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  mask;
  } packed_word_t;

  // Byte-lane enable mask covering the lowest 'filled' lanes.
  function automatic logic [LANES-1:0] lane_mask(input logic [FILL_CNT_W-1:0] filled);
    logic [LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (FILL_CNT_W'(i) < filled) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/depthwise_mram_writer_if.sv
// Pixel stream in plus MRAM port-A write bus out; master is the writer side.
interface depthwise_mram_writer_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  import depthwise_mram_pkg::*;

  logic                  pix_valid;
  logic [LANE_W-1:0]     pix_data;
  logic                  pix_ready;
  logic [ADDR_WIDTH-1:0] mram_addr_a;
  logic [DATA_WIDTH-1:0] mram_din_a;
  logic                  mram_en_a;
  logic [LANES-1:0]      mram_we_a;

  modport master (
    input  pix_valid,
    input  pix_data,
    output pix_ready,
    output mram_addr_a,
    output mram_din_a,
    output mram_en_a,
    output mram_we_a
  );

  modport slave (
    output pix_valid,
    output pix_data,
    input  pix_ready,
    input  mram_addr_a,
    input  mram_din_a,
    input  mram_en_a,
    input  mram_we_a
  );

endinterface

// File: rtl/depthwise_mram_writer_byte_packer.sv
// Packs bytes LSB-first into a word; flags a commit on lane 3 or the last byte.
module mram_byte_packer
  import depthwise_mram_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              push,
  input  logic [LANE_W-1:0] pix_byte,
  input  logic              last,
  output logic [WORD_W-1:0] word_c,
  output logic [LANES-1:0]  mask_c,
  output logic              commit_c
);

  logic [LANE_IDX_W-1:0] lane_q;
  logic [WORD_W-1:0]     acc_q;
  logic [WORD_W-1:0]     merged;

  // Word as it stands with the incoming byte dropped into its lane.
  always_comb begin
    merged                              = acc_q;
    merged[{lane_q, 3'b000} +: LANE_W]  = pix_byte;
    word_c                              = merged;
    mask_c                              = lane_mask(FILL_CNT_W'(lane_q) + FILL_CNT_W'(1));
    commit_c                            = push && ((lane_q == LANE_IDX_W'(LANES - 1)) || last);
  end

  // Committing clears the accumulator on the same edge so the next byte never stalls.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else if (push) begin
      lane_q <= commit_c ? '0 : lane_q + LANE_IDX_W'(1);
      acc_q  <= commit_c ? '0 : merged;
    end
  end

endmodule

// File: rtl/depthwise_mram_writer.sv
// Depthwise conv pixel stream to MRAM port-A writer: packs 4 pixels per word,
// flushes a partial tail with a reduced byte mask and pulses done per frame.
module depthwise_mram_writer
  import depthwise_mram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_STRIDE = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [PIX_CNT_W-1:0]  pix_count,
  depthwise_mram_writer_if.master bus,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [PIX_CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;

  logic                  ready_q;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  packed_word_t          wr_q;

  logic                  accept;
  logic                  frame_start;
  logic                  last_pix;
  logic [WORD_W-1:0]     pk_word;
  logic [LANES-1:0]      pk_mask;
  logic                  pk_commit;

  always_comb begin
    accept      = bus.pix_valid && ready_q;
    frame_start = (state_q == IDLE) && start;
    last_pix    = (rem_q == PIX_CNT_W'(1));
  end

  mram_byte_packer u_packer (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (frame_start),
    .push     (accept),
    .pix_byte (bus.pix_data),
    .last     (last_pix),
    .word_c   (pk_word),
    .mask_c   (pk_mask),
    .commit_c (pk_commit)
  );

  // Frame state, remaining-pixel and word-address registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    waddr_d = waddr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = pix_count;
          waddr_d = base_addr;
          state_d = (pix_count == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          rem_d = rem_q - PIX_CNT_W'(1);
          if (pk_commit) waddr_d = waddr_q + ADDR_WIDTH'(ADDR_STRIDE);
          if (last_pix)  state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags trail the state by one cycle; ready drops on the edge that takes the last pixel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      en_q       <= 1'b0;
      out_addr_q <= '0;
      wr_q       <= '0;
    end else begin
      ready_q <= (state_q == FILL) && (rem_d != '0);
      busy    <= (state_q != IDLE);
      done    <= (state_q == DONE);
      en_q    <= pk_commit;
      if (pk_commit) begin
        out_addr_q <= waddr_q;
        wr_q.data  <= pk_word;
        wr_q.mask  <= pk_mask;
      end
    end
  end

  assign bus.pix_ready   = ready_q;
  assign bus.mram_en_a   = en_q;
  assign bus.mram_addr_a = out_addr_q;
  assign bus.mram_din_a  = DATA_WIDTH'(wr_q.data);
  assign bus.mram_we_a   = wr_q.mask;

endmodule

// File: tb/tb_depthwise_mram_writer.sv
// Bench for depthwise_mram_writer: stride-1 and stride-2 instances share stimulus
// and are compared every cycle against a frame-level model of the write stream.
module tb_depthwise_mram_writer;

  localparam int unsigned AW = 10;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [15:0]     pix_count;
  logic            pix_valid;
  logic [7:0]      pix_data;
  logic            busy1, done1, busy2, done2;

  always #5 clk = ~clk;

  depthwise_mram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus1 ();
  depthwise_mram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus2 ();

  assign bus1.pix_valid = pix_valid;
  assign bus1.pix_data  = pix_data;
  assign bus2.pix_valid = pix_valid;
  assign bus2.pix_data  = pix_data;

  depthwise_mram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .ADDR_STRIDE(1)) u_dut_s1 (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .pix_count(pix_count), .bus(bus1), .busy(busy1), .done(done1)
  );

  depthwise_mram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .ADDR_STRIDE(2)) u_dut_s2 (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .pix_count(pix_count), .bus(bus2), .busy(busy2), .done(done2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: pixels gathered per word, address = base + word_index * stride.
  typedef struct {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [31:0]   d;
    logic [3:0]    we;
    int            cyc;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] m_bytes[$];
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_base  = 0;
  int         m_words = 0;
  int         cyc     = 0;
  int         start_cyc = 0;
  int         done_cyc  = 0;
  int         ready_cyc = -1;
  bit         model_live = 1'b0;

  logic          e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_en = 1'b0;
  logic [AW-1:0] e_addr1 = '0, e_addr2 = '0;
  logic [31:0]   e_din = '0;
  logic [3:0]    e_we  = '0;

  always @(posedge clk) begin : model_p
    int  prev;
    wr_t w;
    cyc++;
    model_live = 1'b1;
    prev = m_phase;
    e_en = 1'b0;
    if (!resetn) begin
      m_phase = 0; m_left = 0; m_bytes.delete();
      e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_addr1 = '0; e_addr2 = '0; e_din = '0; e_we = '0;
    end else begin
      if (prev == 0 && start) begin
        m_base = int'(base_addr); m_left = int'(pix_count); m_words = 0;
        m_bytes.delete(); start_cyc = cyc; ready_cyc = -1;
        m_phase = (pix_count == 16'd0) ? 2 : 1;
      end else if (prev == 1 && pix_valid && e_ready) begin
        m_bytes.push_back(pix_data);
        m_left--;
        if (m_bytes.size() == 4 || m_left == 0) begin
          w.d = '0;
          foreach (m_bytes[i]) w.d = w.d | (32'(m_bytes[i]) << (8 * i));
          w.we  = 4'((1 << m_bytes.size()) - 1);
          w.a1  = AW'((m_base + m_words * 1) % 1024);
          w.a2  = AW'((m_base + m_words * 2) % 1024);
          w.cyc = cyc;
          wlog.push_back(w);
          e_en = 1'b1; e_din = w.d; e_we = w.we; e_addr1 = w.a1; e_addr2 = w.a2;
          m_words++;
          m_bytes.delete();
          if (m_left == 0) m_phase = 2;
        end
      end else if (prev == 2) begin
        m_phase = 0;
      end
      e_busy  = (prev != 0);
      e_done  = (prev == 2);
      e_ready = (prev == 1) && (m_left > 0);
      if (e_done) done_cyc = cyc;
      if (e_ready && ready_cyc < 0) ready_cyc = cyc;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("pix_ready_s1", 32'(bus1.pix_ready), 32'(e_ready));
      check("pix_ready_s2", 32'(bus2.pix_ready), 32'(e_ready));
      check("busy_s1",      32'(busy1),          32'(e_busy));
      check("busy_s2",      32'(busy2),          32'(e_busy));
      check("done_s1",      32'(done1),          32'(e_done));
      check("done_s2",      32'(done2),          32'(e_done));
      check("en_s1",        32'(bus1.mram_en_a), 32'(e_en));
      check("en_s2",        32'(bus2.mram_en_a), 32'(e_en));
      if (e_en) begin
        check("addr_s1", 32'(bus1.mram_addr_a), 32'(e_addr1));
        check("addr_s2", 32'(bus2.mram_addr_a), 32'(e_addr2));
        check("din_s1",  bus1.mram_din_a,       e_din);
        check("din_s2",  bus2.mram_din_a,       e_din);
        check("we_s1",   32'(bus1.mram_we_a),   32'(e_we));
        check("we_s2",   32'(bus2.mram_we_a),   32'(e_we));
      end
    end
  end

  task automatic expect_wr(input string tag, input int i, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [31:0] d, input logic [3:0] we);
    if (i < wlog.size()) begin
      check({tag, "_addr1"}, 32'(wlog[i].a1), 32'(a1));
      check({tag, "_addr2"}, 32'(wlog[i].a2), 32'(a2));
      check({tag, "_data"},  wlog[i].d,       d);
      check({tag, "_we"},    32'(wlog[i].we), 32'(we));
    end else begin
      check({tag, "_present"}, 32'(wlog.size()), 32'(i + 1));
    end
  endtask

  // One frame: start pulse, then pixels p0, p0+1, ... as they are accepted.
  task automatic run_frame(input logic [AW-1:0] b, input int n, input logic [7:0] p0,
                           input bit gaps, input int mid_start, input int abort_after);
    int k;
    int t;
    bit v;
    bit acc;
    k = 0;
    t = 0;
    wlog.delete();
    start = 1'b1; base_addr = b; pix_count = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'h2AA; pix_count = 16'd3;
    while (k < n && t < 200) begin
      v = !gaps || (t % 2 == 0);
      pix_valid = v;
      pix_data  = p0 + 8'(k);
      start     = (k == mid_start);
      if (start) begin base_addr = 10'h300; pix_count = 16'd2; end
      acc = v && (bus1.pix_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) k++;
      t++;
      if (abort_after > 0 && k == abort_after) break;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (abort_after > 0) begin
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      check("rst_busy",  32'(busy1),            32'd0);
      check("rst_done",  32'(done1),            32'd0);
      check("rst_ready", 32'(bus1.pix_ready),   32'd0);
      check("rst_en",    32'(bus1.mram_en_a),   32'd0);
      check("rst_addr",  32'(bus1.mram_addr_a), 32'd0);
      check("rst_din",   bus1.mram_din_a,       32'd0);
      check("rst_we",    32'(bus1.mram_we_a),   32'd0);
    end else if (k < n) begin
      check("frame_timeout", 32'(k), 32'(n));
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; base_addr = '0; pix_count = '0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_en",   32'(bus2.mram_en_a), 32'd0);
    resetn = 1'b1;

    // Full frame, back-to-back
    run_frame(10'h010, 8, 8'h01, 1'b0, -1, 0);
    check("s1_nwr", 32'(wlog.size()), 32'd2);
    expect_wr("s1_w0", 0, 10'h010, 10'h010, 32'h04030201, 4'b1111);
    expect_wr("s1_w1", 1, 10'h011, 10'h012, 32'h08070605, 4'b1111);
    if (wlog.size() == 2) check("s1_done_lat", 32'(done_cyc - wlog[1].cyc), 32'd1);
    check("s1_ready_lat", 32'(ready_cyc - start_cyc), 32'd1);

    // Partial tail
    run_frame(10'h020, 6, 8'hA0, 1'b0, -1, 0);
    check("s2_nwr", 32'(wlog.size()), 32'd2);
    expect_wr("s2_w0", 0, 10'h020, 10'h020, 32'hA3A2A1A0, 4'b1111);
    expect_wr("s2_w1", 1, 10'h021, 10'h022, 32'h0000A5A4, 4'b0011);

    // Address wrap
    run_frame(10'h3FE, 8, 8'h10, 1'b0, -1, 0);
    expect_wr("s3_w0", 0, 10'h3FE, 10'h3FE, 32'h13121110, 4'b1111);
    expect_wr("s3_w1", 1, 10'h3FF, 10'h000, 32'h17161514, 4'b1111);

    // Valid gaps
    run_frame(10'h100, 4, 8'h55, 1'b1, -1, 0);
    check("s4_nwr", 32'(wlog.size()), 32'd1);
    expect_wr("s4_w0", 0, 10'h100, 10'h100, 32'h58575655, 4'b1111);

    // Zero-length frame
    run_frame(10'h123, 0, 8'h00, 1'b0, -1, 0);
    check("s5_nwr", 32'(wlog.size()), 32'd0);
    check("s5_done_lat", 32'(done_cyc - start_cyc), 32'd1);

    // Start pulsed mid-frame is ignored
    run_frame(10'h040, 8, 8'h21, 1'b0, 3, 0);
    check("s6_nwr", 32'(wlog.size()), 32'd2);
    expect_wr("s6_w0", 0, 10'h040, 10'h040, 32'h24232221, 4'b1111);
    expect_wr("s6_w1", 1, 10'h041, 10'h042, 32'h28272625, 4'b1111);

    // Reset after 3 of 8 pixels, then a fresh frame
    run_frame(10'h050, 8, 8'h01, 1'b0, -1, 3);
    check("s7_nwr", 32'(wlog.size()), 32'd0);
    run_frame(10'h010, 8, 8'h01, 1'b0, -1, 0);
    check("s7b_nwr", 32'(wlog.size()), 32'd2);
    expect_wr("s7b_w0", 0, 10'h010, 10'h010, 32'h04030201, 4'b1111);
    expect_wr("s7b_w1", 1, 10'h011, 10'h012, 32'h08070605, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/depthwise_mram_writer.md
# depthwise_mram_writer

Write-side initiator for the depthwise feature-map MRAM. Accepts a valid/ready stream of 8-bit convolution output pixels and packs four consecutive pixels into one 32-bit word, least-significant byte first. Drives the MRAM write port (address, data, enable, byte-enables), tracks frame length, flushes a trailing partial word with a reduced byte mask, and pulses `done` when the frame is fully committed. Sits between the depthwise convolution datapath and the MRAM port A.

## Interface
- `ADDR_WIDTH`, 10, MRAM word-address width.
- `DATA_WIDTH`, 32, MRAM word width; fixed at 4 byte lanes.
- `ADDR_STRIDE`, 1, word-address increment per committed word.
- `clk` in 1: single clock; all logic on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: frame start request; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first word address; latched on accepted `start`.
- `pix_count` in 16: pixels in the frame; latched on accepted `start`.
- `pix_valid` in 1: pixel present.
- `pix_data` in 8: pixel value.
- `pix_ready` out 1: pixel accepted when `pix_valid & pix_ready`.
- `mram_addr_a` out ADDR_WIDTH: write word address.
- `mram_din_a` out 32: packed write data.
- `mram_en_a` out 1: write strobe, one cycle per word.
- `mram_we_a` out 4: byte-lane enables; nonzero whenever `mram_en_a` is high.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle frame-complete pulse.

## Operation
- States:
  - IDLE: waits for `start`.
  - FILL: accepts pixels.
  - DONE: lasts one cycle with `done=1`, then returns to IDLE.
- Frame start:
  - IDLE with `start=1` and `pix_count≠0` → FILL. Latch `base_addr` and `pix_count`, clear lane index and accumulator.
  - IDLE with `start=1` and `pix_count=0` → DONE directly. No writes are issued.
  - `start` is ignored in FILL and DONE.
- Pixel handling:
  - `pix_ready = (state==FILL) && (remaining≠0)`.
  - Each accepted pixel is written into accumulator lane `lane`, bits `[8*lane+7:8*lane]`. `lane` then increments modulo 4 and `remaining` decrements.
- Commit:
  - A word is committed when an accepted pixel fills lane 3 or is the last pixel (`remaining==1`).
  - On commit, the accumulator (including this pixel) is copied to a separate output register:
    - `mram_din_a` takes the accumulator value; unfilled lanes are 0.
    - `mram_we_a` takes the mask of filled lanes: `4'b1111` for a full word, `4'b0001`, `4'b0011` or `4'b0111` for a partial one.
    - `mram_addr_a` takes the current word address.
    - `mram_en_a` is set for exactly one cycle.
  - The accumulator clears in the same edge, so the next pixel is accepted with no stall.
- Addressing:
  - The word address starts at `base_addr`.
  - After each commit it advances by `ADDR_STRIDE`, modulo 2^ADDR_WIDTH; wrap is silent.
- Frame end: after the last pixel's commit, FILL → DONE. `busy` is high in FILL and DONE, low in IDLE.
- Reset: `resetn=0` at any edge clears all state and outputs to 0 and returns to IDLE. A partial word in flight is discarded and `done` is not pulsed.

## Timing
- Reset values: every output reads 0 (`pix_ready`, `mram_*`, `busy`, `done`).
- `start` accepted at edge E: `busy=1` and `pix_ready=1` from E+1.
- Write latency: a pixel accepted at edge T that causes a commit drives `mram_en_a=1` during the cycle after T, i.e. registered at T, visible until T+1.
- Throughput: one pixel per cycle sustained; one write per four pixels.
- Last pixel accepted at T:
  - final write visible in cycle T..T+1;
  - `done=1` in cycle T+1..T+2;
  - `busy=0` from T+2.
- Zero-length frame: `start` at E → `done=1` at E+1, `busy=1` only in that cycle.
- `pix_valid` gaps stall accumulation only. `mram_en_a` is never high without a new commit.

## Structure
- Package `depthwise_mram_pkg`:
  - state enum (IDLE, FILL, DONE);
  - `LANES=4`, `LANE_W=8`;
  - a function that builds the byte mask from a filled-lane count.
- One sub-module, `mram_byte_packer`:
  - contains the lane index, accumulator, mask and commit flag;
  - inputs: push, byte, last, clear;
  - outputs: word, mask, commit.
- The top level holds the FSM, remaining counter, address counter and output registers.

## Test plan
- Full frame: base 0x010, count 8, pixels 0x01..0x08 back-to-back → two writes: addr 0x010 data 0x04030201 we 1111, then addr 0x011 data 0x08070605 we 1111. `done` one cycle after the second write.
- Partial tail: base 0x020, count 6, pixels 0xA0..0xA5 → second write at addr 0x021, data 0x0000A5A4, we 0011.
- Wrap and stride: `ADDR_STRIDE`=2, base 0x3FE, count 8 → writes at 0x3FE then 0x000.
- Backpressure gaps: `pix_valid` toggled every other cycle, count 4 → exactly one write with data equal to the four accepted bytes. `pix_ready` stays high until the 4th pixel is accepted.
- Zero count and ignored `start`: count 0 → `done` at E+1 with no `mram_en_a`. A `start` pulsed mid-frame leaves addresses and counts unchanged.
- Reset mid-frame: `resetn` low after 3 of 8 pixels → no write issued, all outputs 0 the next cycle. A fresh `start` then behaves as in the first scenario.
